// File: rtl/uart_stim_tx.sv
// Bit-serial UART 8N1/8N2 stimulus transmitter with a small byte FIFO on a valid/ready port.
// Optional parity bit is enabled by defining UART_STIM_PARITY_EN (adds the i_par_odd input).
module uart_stim_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          i_clock,
    input  logic                          i_reset_n,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [7:0]                    i_in_bits,
    input  logic [DIV_W-1:0]              i_div,
    input  logic                          i_nstop,
`ifdef UART_STIM_PARITY_EN
    input  logic                          i_par_odd,
`endif
    input  logic                          i_en,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_STIM_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Byte FIFO
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Serializer
    state_t           r_state;
    logic [DIV_W-1:0] r_baud;
    logic [DIV_W-1:0] r_div_l;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_idx;
    logic             r_nstop_l;
    logic             r_stop_two;
    logic             r_tx;
    logic             r_busy;
`ifdef UART_STIM_PARITY_EN
    logic             r_par_odd_l;
`endif

    logic             w_push;
    logic             w_can_pop;
    logic             w_last_bit;
    logic             w_stop_done;
    logic             w_pop;
    logic [2:0]       w_next_idx;

    // Ready comes from the registered count alone, so a full FIFO refuses a push even while popping.
    assign o_in_ready   = (r_count < CNT_W'(FIFO_DEPTH));
    assign o_fifo_count = r_count;
    assign o_tx         = r_tx;
    assign o_busy       = r_busy;

    assign w_push      = i_in_valid && o_in_ready;
    assign w_can_pop   = i_en && (r_count != '0);
    assign w_last_bit  = (r_baud == '0);
    assign w_stop_done = (r_state == S_STOP) && w_last_bit && !r_stop_two;
    assign w_pop       = w_can_pop && ((r_state == S_IDLE) || w_stop_done);
    assign w_next_idx  = r_bit_idx + 3'd1;

    // NOTE: storage carries no reset; only pointers and count define which entries are valid.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_bits;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_baud      <= '0;
            r_div_l     <= '0;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_nstop_l   <= 1'b0;
            r_stop_two  <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
`ifdef UART_STIM_PARITY_EN
            r_par_odd_l <= 1'b0;
`endif
        end else if (w_pop) begin
            // Frame setup from IDLE or straight out of the last stop cycle; line settings latch here only.
            r_shift     <= r_mem[r_rd_ptr];
            r_div_l     <= i_div;
            r_baud      <= i_div;
            r_nstop_l   <= i_nstop;
`ifdef UART_STIM_PARITY_EN
            r_par_odd_l <= i_par_odd;
`endif
            r_state     <= S_START;
            r_tx        <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_START: begin
                    if (w_last_bit) begin
                        r_baud    <= r_div_l;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud - DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_last_bit) begin
                        r_baud <= r_div_l;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_STIM_PARITY_EN
                            r_tx    <= (^r_shift) ^ r_par_odd_l;
                            r_state <= S_PARITY;
`else
                            r_tx       <= 1'b1;
                            r_stop_two <= r_nstop_l;
                            r_state    <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= w_next_idx;
                            r_tx      <= r_shift[w_next_idx];
                        end
                    end else begin
                        r_baud <= r_baud - DIV_W'(1);
                    end
                end
`ifdef UART_STIM_PARITY_EN
                S_PARITY: begin
                    if (w_last_bit) begin
                        r_baud     <= r_div_l;
                        r_tx       <= 1'b1;
                        r_stop_two <= r_nstop_l;
                        r_state    <= S_STOP;
                    end else begin
                        r_baud <= r_baud - DIV_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_last_bit) begin
                        if (r_stop_two) begin
                            r_stop_two <= 1'b0;
                            r_baud     <= r_div_l;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud - DIV_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed bench for uart_stim_tx: a cycle-exact line decoder pops expected bytes from a scoreboard
// queue filled when bytes are offered; directed steps check timing, FIFO limits and reset.
module tb_uart_stim_tx;

    localparam int FIFO_DEPTH = 8;
    localparam int DIV_W      = 16;
`ifdef UART_STIM_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_bits = 8'h00;
    logic [DIV_W-1:0] div = '0;
    logic             nstop = 1'b0;
    logic             en = 1'b0;
    logic             tx;
    logic             busy;
    logic [3:0]       fifo_count;
`ifdef UART_STIM_PARITY_EN
    logic             par_odd = 1'b0;
`endif

    uart_stim_tx #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_in_valid   (in_valid),
        .o_in_ready   (in_ready),
        .i_in_bits    (in_bits),
        .i_div        (div),
        .i_nstop      (nstop),
`ifdef UART_STIM_PARITY_EN
        .i_par_odd    (par_odd),
`endif
        .i_en         (en),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] sb[$];

    // Line settings the decoder assumes; only changed while the line is idle.
    int mon_div = 0;
    int mon_nstop = 0;
    int mon_par_odd = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line decoder: frame timing is exact, so each bit is sampled in its first cycle.
    bit         in_frame = 1'b0;
    logic       prev_tx = 1'b1;
    int         cyc = 0;
    int         per = 1;
    int         flen = 10;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] exp_byte;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            prev_tx  = 1'b1;
        end else if (!in_frame) begin
            if (prev_tx === 1'b1 && tx === 1'b0) begin
                in_frame = 1'b1;
                cyc      = 0;
                per      = mon_div + 1;
                flen     = (10 + PAR_BITS + mon_nstop) * per;
            end
            prev_tx = tx;
        end else begin
            cyc++;
            if (per > 1 && cyc == per - 1) check("start_hold", tx, 1'b0);
            if (cyc >= per && cyc < 9 * per && (cyc % per) == 0) mon_byte[cyc / per - 1] = tx;
            if (PAR_BITS == 1 && cyc == 9 * per)
                check("parity_bit", tx, (^mon_byte) ^ mon_par_odd[0]);
            if (cyc == (9 + PAR_BITS) * per || cyc == flen - 1) check("stop_bit", tx, 1'b1);
            if (cyc == flen - 1) begin
                check("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_byte = sb.pop_front();
                    check("rx_byte", mon_byte, exp_byte);
                end
                in_frame = 1'b0;
            end
            prev_tx = tx;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, compared %0d mismatched %0d", n_cmp, n_mis);
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        int hi;

        // 1) Reset state and quiet idle line
        step(10);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_count", fifo_count, 4'd0);
        rst_n = 1'b1;
        en    = 1'b1;
        lows  = 0;
        repeat (20) begin
            step(1);
            if (tx !== 1'b1) lows++;
        end
        check("idle_tx_low_cycles", lows, 0);

        // 2) Single 0xA5 frame at div=3; settings changed mid-frame must not apply
        div = 16'd3; nstop = 1'b0; mon_div = 3; mon_nstop = 0;
        in_valid = 1'b1; in_bits = 8'hA5; sb.push_back(8'hA5);
        step(1);                                  // push edge T
        in_valid = 1'b0;
        check("t2_count_after_push", fifo_count, 4'd1);
        check("t2_tx_at_T", tx, 1'b1);
        step(1);                                  // T+1
        check("t2_tx_start", tx, 1'b0);
        check("t2_busy_rise", busy, 1'b1);
        check("t2_count_after_pop", fifo_count, 4'd0);
        div = 16'd5; nstop = 1'b1;
        step(3);                                  // T+4
        check("t2_tx_start_end", tx, 1'b0);
        step(36);                                 // T+40, last stop cycle
        check("t2_busy_last_stop", busy, 1'b1);
        check("t2_tx_last_stop", tx, 1'b1);
        step(1);                                  // T+41
        check("t2_busy_fall", busy, 1'b0);

        // 3) Back-to-back frames at div=0
        div = 16'd0; nstop = 1'b0; mon_div = 0; mon_nstop = 0;
        in_valid = 1'b1; in_bits = 8'h55; sb.push_back(8'h55);
        step(1);
        in_bits = 8'h0F; sb.push_back(8'h0F);
        step(1);
        check("t3_busy_rise", busy, 1'b1);
        hi = int'(busy);
        in_bits = 8'hFF; sb.push_back(8'hFF);
        step(1);
        in_valid = 1'b0;
        if (busy) hi++;
        for (int k = 0; k < 100 && busy; k++) begin
            step(1);
            if (busy) hi++;
        end
        check("t3_busy_run_len", hi, 30);
        check("t3_count_empty", fifo_count, 4'd0);

        // 4) Fill with en=0, refuse the 9th byte, then drain in order
        en = 1'b0; div = 16'd1; mon_div = 1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_bits  = 8'h30 + 8'(i);
            if (i < FIFO_DEPTH) sb.push_back(in_bits);
            if (i == FIFO_DEPTH) check("t4_ready_full", in_ready, 1'b0);
            step(1);
        end
        in_valid = 1'b0;
        check("t4_count_full", fifo_count, 4'd8);
        check("t4_ready_low", in_ready, 1'b0);
        step(3);
        check("t4_tx_held_en0", tx, 1'b1);
        check("t4_busy_en0", busy, 1'b0);
        en = 1'b1; in_valid = 1'b1; in_bits = 8'h99;   // offered during the pop edge while full
        step(1);
        in_valid = 1'b0;
        check("t4_ready_after_pop", in_ready, 1'b1);
        check("t4_count_after_pop", fifo_count, 4'd7);
        for (int k = 0; k < 400 && (sb.size() != 0 || busy); k++) step(1);
        check("t4_drained", sb.size(), 0);
        check("t4_busy_idle", busy, 1'b0);

        // 5) Reset mid-DATA abandons the frame; then a clean 8N2 frame
        div = 16'd7; nstop = 1'b1; mon_div = 7; mon_nstop = 1;
        in_valid = 1'b1; in_bits = 8'h80; sb.push_back(8'h80);
        step(1);                                  // push edge
        in_valid = 1'b0;
        in_bits = 8'h80; in_valid = 1'b1;         // second copy queued so count is nonzero at reset
        step(1);
        in_valid = 1'b0;
        step(17);                                 // mid data bit 1
        check("t5_busy_mid", busy, 1'b1);
        check("t5_tx_mid", tx, 1'b0);
        check("t5_count_mid", fifo_count, 4'd1);
        rst_n = 1'b0;
        #1;
        check("t5_tx_reset", tx, 1'b1);
        check("t5_count_reset", fifo_count, 4'd0);
        check("t5_busy_reset", busy, 1'b0);
        sb.delete();
        step(2);
        rst_n = 1'b1;
        in_valid = 1'b1; in_bits = 8'h01; sb.push_back(8'h01);
        step(1);                                  // push edge T
        in_valid = 1'b0;
        step(88);                                 // T+88, last of 16 stop cycles
        check("t5_busy_last_stop", busy, 1'b1);
        step(1);
        check("t5_busy_fall", busy, 1'b0);

`ifdef UART_STIM_PARITY_EN
        // 6) Parity bit values
        div = 16'd1; nstop = 1'b0; mon_div = 1; mon_nstop = 0;
        par_odd = 1'b0; mon_par_odd = 0;
        in_valid = 1'b1; in_bits = 8'h07; sb.push_back(8'h07);
        step(1);
        in_valid = 1'b0;
        step(19);
        check("t6_parity_even", tx, 1'b1);
        for (int k = 0; k < 100 && busy; k++) step(1);
        par_odd = 1'b1; mon_par_odd = 1;
        in_valid = 1'b1; in_bits = 8'h03; sb.push_back(8'h03);
        step(1);
        in_valid = 1'b0;
        step(19);
        check("t6_parity_odd", tx, 1'b1);
        for (int k = 0; k < 100 && busy; k++) step(1);
`endif

        step(4);
        check("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
